// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and datapath muxes.
// The optional bne support in the top level is enabled by defining MC_BNE_EN.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: (ALUOp, FUNCT) -> ALU control code.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;  // add and unknown FUNCT both add
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath (Moore, 12 states).
// Define MC_BNE_EN to decode bne (OP 000101) as a branch on ~ZERO.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W     = 6,
  parameter int unsigned ALUCTL_W = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OP_W-1:0]     OP,
  input  logic [OP_W-1:0]     FUNCT,
  input  logic                ZERO,
  output logic                IORD,
  output logic                IRWRITE,
  output logic                MEMWRITE,
  output logic                MEMTOREG,
  output logic                REGDST,
  output logic                REGWRITE,
  output logic                ALUSRCA,
  output logic [1:0]          ALUSRCB,
  output logic [1:0]          PCSRC,
  output logic                PCEN,
  output logic [ALUCTL_W-1:0] ALUCONTROL,
  output logic [3:0]          STATE
);

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch, branch_cond;
  logic       irwrite_s, memwrite_s, regwrite_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StFetch;
    else     state_q <= state_d;
  end

`ifdef MC_BNE_EN
  logic bne_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        bne_q <= 1'b0;
    else if (state_q == StDecode)   bne_q <= (OP == OP_BNE);
  end

  assign branch_cond = bne_q ? ~ZERO : ZERO;
`else
  assign branch_cond = ZERO;
`endif

  always_comb begin
    state_d    = StFetch;
    IORD       = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    MEMTOREG   = 1'b0;
    REGDST     = 1'b0;
    regwrite_s = 1'b0;
    ALUSRCA    = 1'b0;
    ALUSRCB    = ALUSRCB_B;
    PCSRC      = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (state_q)
      StFetch: begin
        ALUSRCB   = ALUSRCB_FOUR;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        ALUSRCB = ALUSRCB_IMMSH;
        case (OP)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = StBranch;
`endif
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJump;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSRCA = 1'b1;
        ALUSRCB = ALUSRCB_IMM;
        state_d = (OP == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        IORD    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        MEMTOREG   = 1'b1;
        regwrite_s = 1'b1;
      end
      StMemWr: begin
        IORD       = 1'b1;
        memwrite_s = 1'b1;
      end
      StExecute: begin
        ALUSRCA = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = StAluWb;
      end
      StAluWb: begin
        REGDST     = 1'b1;
        regwrite_s = 1'b1;
      end
      StBranch: begin
        ALUSRCA = 1'b1;
        aluop   = ALUOP_SUB;
        PCSRC   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      StAddiEx: begin
        ALUSRCA = 1'b1;
        ALUSRCB = ALUSRCB_IMM;
        state_d = StAddiWb;
      end
      StAddiWb: regwrite_s = 1'b1;
      StJump: begin
        PCSRC   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: state_d = StFetch;  // encodings 12..15 recover to FETCH
    endcase
  end

  // Reset gates every write enable so an abandoned instruction leaves no partial update.
  assign IRWRITE  = irwrite_s & ~RST;
  assign MEMWRITE = memwrite_s & ~RST;
  assign REGWRITE = regwrite_s & ~RST;
  assign PCEN     = (pcwrite | (branch & branch_cond)) & ~RST;
  assign STATE    = state_q;

  mips_alu_decoder u_alu_decoder (
    .aluop     (aluop),
    .funct     (FUNCT),
    .alucontrol(ALUCONTROL)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control (bne checks follow MC_BNE_EN).
module tb_mips_multicycle_control;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] OP = 6'b111111;
  logic [5:0] FUNCT = 6'b000000;
  logic       ZERO = 1'b0;
  logic       IORD, IRWRITE, MEMWRITE, MEMTOREG, REGDST, REGWRITE, ALUSRCA, PCEN;
  logic [1:0] ALUSRCB, PCSRC;
  logic [2:0] ALUCONTROL;
  logic [3:0] STATE;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control dut (
    .CLK       (CLK),
    .RST       (RST),
    .OP        (OP),
    .FUNCT     (FUNCT),
    .ZERO      (ZERO),
    .IORD      (IORD),
    .IRWRITE   (IRWRITE),
    .MEMWRITE  (MEMWRITE),
    .MEMTOREG  (MEMTOREG),
    .REGDST    (REGDST),
    .REGWRITE  (REGWRITE),
    .ALUSRCA   (ALUSRCA),
    .ALUSRCB   (ALUSRCB),
    .PCSRC     (PCSRC),
    .PCEN      (PCEN),
    .ALUCONTROL(ALUCONTROL),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", STATE); end
    checks++; if ({IRWRITE, MEMWRITE, REGWRITE, PCEN} !== 4'b0000) begin
      errors++; $display("FAIL rst_enables got %b want 0000", {IRWRITE, MEMWRITE, REGWRITE, PCEN});
    end
    checks++; if (ALUSRCB !== 2'b01) begin errors++; $display("FAIL rst_alusrcb got %b want 01", ALUSRCB); end
    tick();
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL rst_hold got %0d want 0", STATE); end
    #3 RST = 1'b0;
    #1;
    checks++; if ({IRWRITE, PCEN} !== 2'b11) begin errors++; $display("FAIL fetch_en got %b want 11", {IRWRITE, PCEN}); end
    OP = 6'b101011;  // sw, to be interrupted in MEMWR
    tick();
    checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL sw_decode got %0d want 1", STATE); end
    tick();
    checks++; if (STATE !== 4'd2) begin errors++; $display("FAIL sw_memadr got %0d want 2", STATE); end
    tick();
    checks++; if (STATE !== 4'd5) begin errors++; $display("FAIL sw_memwr got %0d want 5", STATE); end
    checks++; if ({MEMWRITE, IORD} !== 2'b11) begin errors++; $display("FAIL sw_memwr_en got %b want 11", {MEMWRITE, IORD}); end
    #2 RST = 1'b1;
    #1;
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL async_rst_state got %0d want 0", STATE); end
    checks++; if (MEMWRITE !== 1'b0) begin errors++; $display("FAIL async_rst_memwrite got %b want 0", MEMWRITE); end
    @(negedge CLK);
    RST = 1'b0;
    OP = 6'b111111;
    #1;
    checks++; if ({PCEN, ALUSRCB} !== 3'b101) begin errors++; $display("FAIL post_rst_pc got %b want 101", {PCEN, ALUSRCB}); end
    tick();
    checks++; if (STATE !== 4'd1) begin errors++; $display("FAIL post_rst_decode got %0d want 1", STATE); end
    tick();
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL post_rst_fetch got %0d want 0", STATE); end
  endtask

  task automatic test_lw();
    logic [3:0] seq [5];
    int cycles;
    seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd2; seq[3] = 4'd3; seq[4] = 4'd4;
    OP = 6'b100011;
    cycles = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (STATE !== seq[i]) begin errors++; $display("FAIL lw_seq[%0d] got %0d want %0d", i, STATE, seq[i]); end
      checks++; if ({REGWRITE, MEMTOREG} !== ((i == 4) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL lw_wb[%0d] got %b", i, {REGWRITE, MEMTOREG});
      end
      if (i == 2) begin
        checks++; if ({ALUSRCA, ALUSRCB} !== 3'b110) begin errors++; $display("FAIL lw_memadr got %b want 110", {ALUSRCA, ALUSRCB}); end
      end
      if (i == 3) begin
        checks++; if (IORD !== 1'b1) begin errors++; $display("FAIL lw_iord got %b want 1", IORD); end
      end
      tick();
      cycles++;
    end
    checks++; if (STATE !== 4'd0 || cycles != 5) begin errors++; $display("FAIL lw_latency state %0d want 0", STATE); end
  endtask

  task automatic test_rtype(input logic [5:0] funct, input logic [2:0] exp_ctl);
    OP = 6'b000000;
    FUNCT = funct;
    tick();
    checks++; if (ALUSRCB !== 2'b11) begin errors++; $display("FAIL decode_alusrcb got %b want 11", ALUSRCB); end
    tick();
    checks++; if (STATE !== 4'd6) begin errors++; $display("FAIL r_execute got %0d want 6", STATE); end
    checks++; if (ALUCONTROL !== exp_ctl) begin
      errors++; $display("FAIL r_alucontrol funct %b got %b want %b", funct, ALUCONTROL, exp_ctl);
    end
    tick();
    checks++; if ({STATE, REGDST, REGWRITE, MEMTOREG} !== {4'd7, 3'b110}) begin
      errors++; $display("FAIL r_aluwb got %0d/%b want 7/110", STATE, {REGDST, REGWRITE, MEMTOREG});
    end
    tick();
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL r_return got %0d want 0", STATE); end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic zero, input logic exp_pcen);
    OP = op;
    tick();
    tick();
    ZERO = zero;
    #1;
    checks++; if ({STATE, PCSRC, PCEN} !== {4'd8, 2'b01, exp_pcen}) begin
      errors++; $display("FAIL branch op %b zero %b got %0d/%b/%b want 8/01/%b", op, zero, STATE, PCSRC, PCEN, exp_pcen);
    end
    checks++; if (ALUCONTROL !== 3'b110) begin errors++; $display("FAIL branch_sub got %b want 110", ALUCONTROL); end
    tick();
    ZERO = 1'b0;
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL branch_return got %0d want 0", STATE); end
  endtask

  task automatic test_jump_addi();
    OP = 6'b000010;
    tick();
    tick();
    checks++; if ({STATE, PCSRC, PCEN} !== {4'd11, 2'b10, 1'b1}) begin
      errors++; $display("FAIL jump got %0d/%b/%b want 11/10/1", STATE, PCSRC, PCEN);
    end
    tick();
    OP = 6'b001000;
    tick();
    tick();
    checks++; if ({STATE, ALUSRCA, ALUSRCB, ALUCONTROL} !== {4'd9, 3'b110, 3'b010}) begin
      errors++; $display("FAIL addiex got %0d/%b/%b want 9/110/010", STATE, {ALUSRCA, ALUSRCB}, ALUCONTROL);
    end
    tick();
    checks++; if ({STATE, REGWRITE, REGDST, MEMTOREG} !== {4'd10, 3'b100}) begin
      errors++; $display("FAIL addiwb got %0d/%b want 10/100", STATE, {REGWRITE, REGDST, MEMTOREG});
    end
    tick();
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL addi_return got %0d want 0", STATE); end
  endtask

  task automatic test_nop(input logic [5:0] op);
    OP = op;
    tick();
    checks++; if ({STATE, IRWRITE, MEMWRITE, REGWRITE, PCEN} !== {4'd1, 4'b0000}) begin
      errors++; $display("FAIL nop_decode op %b got %0d/%b", op, STATE, {IRWRITE, MEMWRITE, REGWRITE, PCEN});
    end
    tick();
    checks++; if (STATE !== 4'd0) begin errors++; $display("FAIL nop_return op %b got %0d want 0", op, STATE); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype(6'b100010, 3'b110);
    test_rtype(6'b101010, 3'b111);
    test_rtype(6'b100101, 3'b001);
    test_rtype(6'b111111, 3'b010);
    test_branch(6'b000100, 1'b1, 1'b1);
    test_branch(6'b000100, 1'b0, 1'b0);
    test_jump_addi();
    test_nop(6'b111111);
`ifdef MC_BNE_EN
    test_branch(6'b000101, 1'b0, 1'b1);
    test_branch(6'b000101, 1'b1, 1'b0);
    test_branch(6'b000100, 1'b1, 1'b1);
`else
    test_nop(6'b000101);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
